// File: rtl/mem_arb_pkg.sv
// Shared types for the cache/memory arbiter: FSM states, requester ids and the
// line-offset helper used to align burst base addresses.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST_I = 2'd1,
        BURST_D = 2'd2,
        DONE    = 2'd3
    } t_arb_state;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } t_requester;

    // Number of low address bits covered by one cache line.
    function automatic int unsigned line_offset_bits(input int unsigned burst_len,
                                                     input int unsigned data_width);
        return $clog2(burst_len * data_width / 8);
    endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares one backing-memory port between the I-cache and D-cache line engines:
// round-robin grant on ties, fixed-length beat bursts, one-cycle done pulse.
module cache_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_icache_req,
    input  logic [ADDR_WIDTH-1:0]        i_icache_addr,
    output logic                         o_icache_gnt,
    output logic                         o_icache_rvalid,
    output logic                         o_icache_done,
    input  logic                         i_dcache_req,
    input  logic                         i_dcache_we,
    input  logic [ADDR_WIDTH-1:0]        i_dcache_addr,
    input  logic [DATA_WIDTH-1:0]        i_dcache_wdata,
    output logic                         o_dcache_gnt,
    output logic                         o_dcache_rvalid,
    output logic                         o_dcache_wready,
    output logic                         o_dcache_done,
    output logic [DATA_WIDTH-1:0]        o_rdata,
    output logic [$clog2(BURST_LEN)-1:0] o_beat,
    output logic                         o_mem_req,
    output logic                         o_mem_we,
    output logic [ADDR_WIDTH-1:0]        o_mem_addr,
    output logic [DATA_WIDTH-1:0]        o_mem_wdata,
    input  logic                         i_mem_ready,
    input  logic [DATA_WIDTH-1:0]        i_mem_rdata
);

    localparam int unsigned BEAT_W     = $clog2(BURST_LEN);
    localparam int unsigned BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int unsigned LINE_OFFS  = line_offset_bits(BURST_LEN, DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << LINE_OFFS) - ADDR_WIDTH'(1));
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    t_arb_state            state_q, state_d;
    t_requester            last_q, last_d;
    t_requester            gnt_sel;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  we_q, we_d;
    logic                  in_burst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= REQ_I;
            beat_q  <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            we_q    <= we_d;
        end
    end

    // Arbitration, burst sequencing and beat counting.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        beat_d  = beat_q;
        base_d  = base_q;
        we_d    = we_q;
        gnt_sel = REQ_I;
        unique case (state_q)
            IDLE: begin
                if (i_icache_req && i_dcache_req) begin
                    gnt_sel = (last_q == REQ_I) ? REQ_D : REQ_I;
                end else begin
                    gnt_sel = i_dcache_req ? REQ_D : REQ_I;
                end
                if (i_icache_req || i_dcache_req) begin
                    last_d = gnt_sel;
                    beat_d = '0;
                    if (gnt_sel == REQ_D) begin
                        state_d = BURST_D;
                        base_d  = i_dcache_addr & LINE_MASK;
                        we_d    = i_dcache_we;
                    end else begin
                        state_d = BURST_I;
                        base_d  = i_icache_addr & LINE_MASK;
                        we_d    = 1'b0;
                    end
                end
            end
            BURST_I, BURST_D: begin
                if (i_mem_ready) begin
                    // The final beat returns the counter to zero as the burst ends.
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Port outputs; only rvalid/wready and the data pass-throughs see inputs.
    always_comb begin
        in_burst        = (state_q == BURST_I) || (state_q == BURST_D);
        o_icache_gnt    = (state_q == BURST_I);
        o_dcache_gnt    = (state_q == BURST_D);
        o_mem_req       = in_burst;
        o_mem_we        = (state_q == BURST_D) && we_q;
        o_icache_rvalid = (state_q == BURST_I) && i_mem_ready;
        o_dcache_rvalid = (state_q == BURST_D) && !we_q && i_mem_ready;
        o_dcache_wready = (state_q == BURST_D) && we_q && i_mem_ready;
        o_icache_done   = (state_q == DONE) && (last_q == REQ_I);
        o_dcache_done   = (state_q == DONE) && (last_q == REQ_D);
        o_beat          = beat_q;
        o_mem_addr      = in_burst ? (base_q + (ADDR_WIDTH'(beat_q) << BYTE_SHIFT)) : '0;
        o_mem_wdata     = o_mem_we ? i_dcache_wdata : '0;
        o_rdata         = i_mem_rdata;
    end

endmodule
